sync_up_counter_tff: RTL



---
 rtl/sync_up_counter_tff.sv | 65 ++++++
 1 files changed

// File: rtl/sync_up_counter_tff.sv
// Synchronous modulo-MODULUS up counter built from T flip-flop cells, with
// parallel load, synchronous clear, terminal count, registered carry and sticky overflow.
module sync_up_counter_tff #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             carry,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  logic             at_term;
  logic             wrap;
  logic             run;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] load_val;

  assign at_term  = (q == TERM);
  assign tc       = at_term;
  assign wrap     = t & at_term;
  assign qn       = ~q;
  assign load_val = (d > TERM) ? TERM : d;

  // Bit i toggles when t and every lower bit is set; at terminal count every
  // set bit toggles instead, which returns the count to zero for any modulus.
  always_comb begin
    toggle = '0;
    run    = t;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = run;
      run       = run & q[i];
    end
    if (wrap) begin
      toggle = q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q     <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (ld) begin
      q     <= load_val;
      carry <= 1'b0;
    end else begin
      q     <= q ^ toggle;
      carry <= wrap;
      if (wrap) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
